ee457_fetch_ctrl: RTL

EE457_FETCH_CTRL -- requirements
Module: ee457_fetch_ctrl

---
 rtl/ee457_fetch_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/ee457_fetch_ctrl.sv
// Instruction-fetch controller for a 5-stage pipeline: PC register, IF/ID latch,
// redirect/hold/advance sequencing, stall/flush performance counters and a
// sticky hazard-unit consistency flag.
module ee457_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             pcwrite,
    input  logic             irwrite,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             id_ex_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_pc4;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             r_err;

    logic [31:0]      w_pc4;
    logic             w_hdu_bad;

    // Wraps modulo 2^32 by construction of the 32-bit sum.
    assign w_pc4     = r_pc + 32'd4;
    // The hazard unit must drive pcwrite and irwrite as the inverse of stall.
    assign w_hdu_bad = (pcwrite == stall) || (irwrite == stall);

    // NOTE: every register below uses non-blocking assignment so all next-state
    // terms read the pre-edge values, matching the flop behaviour being modelled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_instr     <= 32'h0;
            r_pc4       <= 32'h0;
            r_valid     <= 1'b0;
            r_state     <= BOOT;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_hdu_bad) begin
                r_err <= 1'b1;
            end
            if (br_taken) begin
                // Redirect beats a simultaneous stall; the stall is not counted.
                r_pc    <= {br_target[31:2], 2'b00};
                r_instr <= 32'h0;
                r_valid <= 1'b0;
                r_state <= FLUSH;
                if (r_flush_cnt != CNT_MAX) begin
                    r_flush_cnt <= r_flush_cnt + CNT_ONE;
                end
            end else if (stall) begin
                r_state <= STALL;
                if (r_stall_cnt != CNT_MAX) begin
                    r_stall_cnt <= r_stall_cnt + CNT_ONE;
                end
            end else begin
                r_pc    <= w_pc4;
                r_instr <= imem_rdata;
                r_pc4   <= w_pc4;
                r_valid <= 1'b1;
                r_state <= RUN;
            end
        end
    end

    assign pc           = r_pc;
    assign if_id_instr  = r_instr;
    assign if_id_pc4    = r_pc4;
    assign if_id_valid  = r_valid;
    assign state        = r_state;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;
    assign err          = r_err;
    // Combinational so the ID/EX bubble lands in the same cycle as the request,
    // independent of reset.
    assign id_ex_bubble = stall | br_taken;

endmodule
